// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is split over STAGES registered chunks behind valid/ready.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SAT_EN (adds the `sat` input).

module addsub_stage #(
  parameter int WIDTH = 16,
  parameter int C     = 4,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
);
  logic [C:0] sum;

  always_comb begin
    sum              = {1'b0, a[K*C +: C]} + {1'b0, b[K*C +: C]} + {{C{1'b0}}, c_in};
    s_out            = s_in;
    s_out[K*C +: C]  = sum[C-1:0];
    c_out            = sum[C];
  end
endmodule

module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int C = WIDTH / STAGES;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0]    a_p, b_p, s_p, s_nx;
  logic [STAGES-1:0]               c_p, c_nx;
`ifdef ADDSUB_SAT_EN
  logic [STAGES-1:0]               sat_p;
`endif
  logic                            adv;
  logic                            a_msb, b_msb, ovf_nx;
  logic [WIDTH-1:0]                s_fin;

  // One global advance: the whole pipe shifts or the whole pipe holds.
  assign adv       = ~vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    addsub_stage #(.WIDTH(WIDTH), .C(C), .K(k)) u_stg (
      .a     (a_p[k]),
      .b     (b_p[k]),
      .s_in  (s_p[k]),
      .c_in  (c_p[k]),
      .s_out (s_nx[k]),
      .c_out (c_nx[k])
    );
  end

  // b_p already holds the effective (inverted for subtract) operand, so flags need no sub bit.
  always_comb begin
    a_msb  = a_p[STAGES-1][WIDTH-1];
    b_msb  = b_p[STAGES-1][WIDTH-1];
    ovf_nx = (a_msb == b_msb) && (s_nx[STAGES-1][WIDTH-1] != a_msb);
    s_fin  = s_nx[STAGES-1];
`ifdef ADDSUB_SAT_EN
    if (sat_p[STAGES-1] && ovf_nx)
      s_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_p      <= '0;
      b_p      <= '0;
      s_p      <= '0;
      c_p      <= '0;
`ifdef ADDSUB_SAT_EN
      sat_p    <= '0;
`endif
      s        <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      a_p[0]   <= a;
      b_p[0]   <= sub ? ~b : b;
      c_p[0]   <= sub ? ~cin : cin;
      s_p[0]   <= '0;
`ifdef ADDSUB_SAT_EN
      sat_p[0] <= sat;
`endif
      for (int k = 1; k < STAGES; k++) begin
        a_p[k]   <= a_p[k-1];
        b_p[k]   <= b_p[k-1];
        s_p[k]   <= s_nx[k-1];
        c_p[k]   <= c_nx[k-1];
`ifdef ADDSUB_SAT_EN
        sat_p[k] <= sat_p[k-1];
`endif
      end
      s        <= s_fin;
      cout     <= c_nx[STAGES-1];
      ovf      <= ovf_nx;
      zero     <= (s_fin == '0);
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: STAGES=4 main instance plus STAGES=1 and STAGES=16 instances for the sweep.
module tb_addsub_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin, sub, sat;
  logic        out_ready;
  logic        one;
  logic [2:0]  irdy, ovv, co, ofl, zr;
  logic [15:0] so [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub, sat;
    logic [15:0] s;
    logic        c, o, z;
  } vec_t;

  addsub_pipe #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(ovv[0]), .out_ready(out_ready),
    .s(so[0]), .cout(co[0]), .ovf(ofl[0]), .zero(zr[0]));

  addsub_pipe #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(ovv[1]), .out_ready(one),
    .s(so[1]), .cout(co[1]), .ovf(ofl[1]), .zero(zr[1]));

  addsub_pipe #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(ovv[2]), .out_ready(one),
    .s(so[2]), .cout(co[2]), .ovf(ofl[2]), .zero(zr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] ref_model(input logic [15:0] fa, fb, input logic fcin, fsub);
    logic [16:0] r;
    logic [15:0] be;
    logic        o;
    be = fsub ? ~fb : fb;
    r  = {1'b0, fa} + {1'b0, be} + {16'd0, fsub ? ~fcin : fcin};
    o  = (fa[15] == be[15]) && (r[15] != fa[15]);
    return {r[16], o, (r[15:0] == 16'd0), r[15:0]};
  endfunction

  // Issue one beat with out_ready=1 and wait for its result; returns latency in edges after accept.
  task automatic run_one(input logic [15:0] ta, tb2, input logic tcin, tsub, tsat,
                         output logic [15:0] rs, output logic rc, ro, rz, output int lat);
    in_valid = 1'b1; a = ta; b = tb2; cin = tcin; sub = tsub; sat = tsat;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ovv[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = so[0]; rc = co[0]; ro = ofl[0]; rz = zr[0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovv[0] !== 1'b0 || so[0] !== 16'h0 || co[0] !== 1'b0 || ofl[0] !== 1'b0 || zr[0] !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b z=%b, want all 0", ovv[0], so[0], co[0], ofl[0], zr[0]); end
    checks++;
    if (irdy[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, want 1", irdy[0]); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] rs; logic rc, ro, rz; int lat;
    run_one(16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d, want 4", lat); end
    checks++;
    if ({rs, rc, ro, rz} !== {16'h0046, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL basic_result: got s=%h c=%b o=%b z=%b, want s=0046 c=0 o=0 z=0", rs, rc, ro, rz); end
  endtask

  task automatic test_vectors();
    vec_t vt[$];
    logic [15:0] rs; logic rc, ro, rz; int lat;
    vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
    vt.push_back('{16'h0034, 16'h0012, 1'b0, 1'b1, 1'b0, 16'h0022, 1'b1, 1'b0, 1'b0});
    vt.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0});
    vt.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0});
    vt.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0});
    vt.push_back('{16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0});
`ifdef ADDSUB_SAT_EN
    vt.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0});
    vt.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0});
    vt.push_back('{16'h0012, 16'h0034, 1'b0, 1'b0, 1'b1, 16'h0046, 1'b0, 1'b0, 1'b0});
`endif
    foreach (vt[i]) begin
      run_one(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].sat, rs, rc, ro, rz, lat);
      checks++;
      if ({rs, rc, ro, rz, lat} !== {vt[i].s, vt[i].c, vt[i].o, vt[i].z, 32'd4})
        begin errors++; $display("FAIL vec%0d: got s=%h c=%b o=%b z=%b lat=%0d, want s=%h c=%b o=%b z=%b lat=4",
          i, rs, rc, ro, rz, lat, vt[i].s, vt[i].c, vt[i].o, vt[i].z); end
    end
    sat = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [8] = '{16'h12, 16'h56, 16'h9A, 16'hDE, 16'h34, 16'h78, 16'hBC, 16'hF0};
    logic [15:0] pb [8] = '{16'h34, 16'h78, 16'hBC, 16'hF0, 16'h12, 16'h56, 16'h9A, 16'hDE};
    logic [15:0] ex [8] = '{16'h0046, 16'h00CE, 16'h0156, 16'h01CE, 16'h0046, 16'h00CE, 16'h0156, 16'h01CE};
    logic [16:0] got[$];
    int idx = 0;
    int cyc = 0;
    while (got.size() < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (idx < 8) begin in_valid = 1'b1; a = pa[idx]; b = pb[idx]; cin = 1'b0; sub = 1'b0; end
      else in_valid = 1'b0;
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        checks++;
        if (irdy[0] !== 1'b0 || ovv[0] !== 1'b1)
          begin errors++; $display("FAIL stall_ready cyc%0d: got in_ready=%b out_valid=%b, want 0/1", cyc, irdy[0], ovv[0]); end
      end
      if (cyc >= 6 && cyc <= 9) begin
        checks++;
        if (so[0] !== 16'h00CE) begin errors++; $display("FAIL stall_hold cyc%0d: got s=%h, want 00ce", cyc, so[0]); end
      end
      if (ovv[0] && out_ready) got.push_back({co[0], so[0]});
      if (in_valid && irdy[0]) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d results, want 8", got.size()); end
    foreach (got[i]) begin
      checks++;
      if (i >= 8 || got[i] !== {1'b0, ex[i]})
        begin errors++; $display("FAIL b2b_result%0d: got %h, want %h", i, got[i], (i < 8) ? {1'b0, ex[i]} : 17'h0); end
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ovv[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid=%b, want 0", ovv[0]); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] rs; logic rc, ro, rz; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(i + 1); b = 16'h0001; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ovv[0] !== 1'b0 || so[0] !== 16'h0 || co[0] !== 1'b0 || ofl[0] !== 1'b0 || zr[0] !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs: got v=%b s=%h c=%b o=%b z=%b, want all 0", ovv[0], so[0], co[0], ofl[0], zr[0]); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ovv[0] !== 1'b0) begin errors++; $display("FAIL midreset_stale cyc%0d: got out_valid=%b, want 0", i, ovv[0]); end
    end
    run_one(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    checks++;
    if (lat !== 4 || rs !== 16'h0123)
      begin errors++; $display("FAIL midreset_next: got s=%h lat=%0d, want s=0123 lat=4", rs, lat); end
  endtask

  task automatic test_sweep();
    logic [15:0] ra [40], rb [40];
    logic        rc [40], rsb [40];
    logic [18:0] ex [40];
    int ptr [3] = '{0, 0, 0};
    int lt  [3] = '{4, 1, 16};
    logic [18:0] obs;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      rc[i] = 1'($urandom_range(0, 1)); rsb[i] = 1'($urandom_range(0, 1));
      if (i == 0) begin ra[i] = 16'hFFFF; rb[i] = 16'h0001; rc[i] = 1'b0; rsb[i] = 1'b0; end
      ex[i] = ref_model(ra[i], rb[i], rc[i], rsb[i]);
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        if (ovv[d]) begin
          obs = {co[d], ofl[d], zr[d], so[d]};
          checks++;
          if (ptr[d] >= 40) begin
            errors++; $display("FAIL sweep_L%0d extra result at cyc%0d: got %h, want none", lt[d], cyc, obs);
          end else if (obs !== ex[ptr[d]] || cyc != ptr[d] + lt[d] + 1) begin
            errors++; $display("FAIL sweep_L%0d beat%0d: got {c,o,z,s}=%h at cyc%0d, want %h at cyc%0d",
              lt[d], ptr[d], obs, cyc, ex[ptr[d]], ptr[d] + lt[d] + 1);
          end
          ptr[d]++;
        end
      end
      if (cyc < 40) begin in_valid = 1'b1; a = ra[cyc]; b = rb[cyc]; cin = rc[cyc]; sub = rsb[cyc]; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ptr[d] != 40) begin errors++; $display("FAIL sweep_count_L%0d: got %0d, want 40", lt[d], ptr[d]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1; one = 1'b1;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined adder/subtractor that replaces the fixed 16-bit combinational ripple adder in the datapath once the target clock no longer fits a full-width carry chain. Operands enter through a valid/ready handshake. The carry chain is split across `STAGES` registered chunks. Sum, carry and status flags leave through a second valid/ready handshake after `STAGES` cycles. It sits between the register-file read ports and the writeback mux, and serves any multi-cycle arithmetic path.

## Interface
- `WIDTH`, 16, operand and result width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4, pipeline depth; each stage resolves `WIDTH/STAGES` bits of the carry chain; range 1..WIDTH.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand beat present.
- `in_ready`  output  1  block accepts a beat this cycle.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in (add) or borrow-in (sub).
- `sub`  input  1  0 = add, 1 = subtract.
- `out_valid`  output  1  result beat present.
- `out_ready`  input  1  downstream accepts the result.
- `s`  output  WIDTH  result.
- `cout`  output  1  carry-out; for subtract, 1 = no borrow.
- `ovf`  output  1  two's-complement signed overflow.
- `zero`  output  1  `s == 0`.

## Operation
- Add: `{cout,s} = a + b + cin`.
- Subtract: `{cout,s} = a + ~b + ~cin`, which equals `a - b - cin`.
- `ovf` = (sign of effective A == sign of effective B) && (sign of `s` != sign of A). Effective B is `~b` for subtract.
- Stage k (0-based) adds bits [k·C +: C], where C = WIDTH/STAGES, using the carry registered by stage k-1.
- Operand bits for higher chunks are delayed in skew registers. Completed lower result bits are carried forward alongside them.
- `zero` and `ovf` are computed in the final stage from the full result. `sub` travels with the beat.
- Each stage holds a valid bit. Global advance: `adv = ~out_valid | out_ready`.
  - When `adv` = 1, every stage shifts one position. Stage 0 loads `in_valid` and its operands.
  - When `adv` = 0, all stages hold.
- `in_ready = adv`. A beat transfers on `in_valid & in_ready`. A result retires on `out_valid & out_ready`.
- Bubbles travel as invalid stages. Data fields of invalid stages are don't-care, but `s`/flags must not change while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` and `s` never depend combinationally on `in_valid`, `a` or `b`. `in_ready` depends combinationally on `out_ready` only.

## Timing
- Reset (async assert, release on a clock edge):
  - All stage valid bits clear.
  - `out_valid`=0, `s`=0, `cout`=0, `ovf`=0, `zero`=0.
  - `in_ready`=1.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+STAGES, provided no stall occurred.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall: each cycle with `out_valid`=1 and `out_ready`=0 adds one cycle of latency to every beat in flight. No beat is lost or duplicated.
- Simultaneous accept and retire in the same cycle is legal and keeps full throughput.
- Reset mid-operation: all in-flight beats are discarded. No stale `out_valid` appears after release.
- `STAGES`=1: single registered stage, latency 1, full-width carry in one cycle.
- Carry wrap: `0xFFFF + 0x0001` gives `s`=0, `cout`=1 with no special casing.

## Configuration
- `ADDSUB_SAT_EN` defined:
  - Adds input port `sat` (1 bit), which travels with the beat.
  - When `sat`=1 and `ovf`=1, `s` clamps to the signed max (`0111…1`) on positive overflow or the signed min (`1000…0`) on negative overflow.
  - `ovf` still reports 1. `zero` reflects the clamped value.
- Not defined: `sat` port absent; the result always wraps modulo 2^WIDTH.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1: `a`=0x0012, `b`=0x0034, add, cin=0 -> `s`=0x0046, cout=0, ovf=0, zero=0, `out_valid` exactly 4 cycles after accept.
- Add `0xFFFF + 0x0001`, cin=0 -> `s`=0x0000, cout=1, zero=1, ovf=0. Sub `0x0034 - 0x0012`, cin=0 -> `s`=0x0022, cout=1.
- Add `0x7FFF + 0x0001` -> `s`=0x8000, ovf=1. With `ADDSUB_SAT_EN` and sat=1 -> `s`=0x7FFF, ovf=1. Sub `0x8000 - 0x0001` with sat=1 -> `s`=0x8000, ovf=1.
- Stream 8 back-to-back beats (0x12+0x34, 0x56+0x78, 0x9A+0xBC, 0xDE+0xF0 and the four swapped-operand pairs). Hold `out_ready`=0 for 3 cycles mid-stream -> `in_ready`=0 during the stall, `s` stable, all 8 results in order (0x46, 0xCE, 0x156→`s`=0x0156, 0x1CE, …), no loss or duplication.
- Assert `rst_n`=0 with 3 beats in flight -> outputs zero immediately, `out_valid` stays 0 for 4+ cycles after release, and the next beat behaves per nominal latency.
- Sweep STAGES=1 and STAGES=16 with WIDTH=16 on random vectors against a reference model -> identical results, latency = STAGES.
